// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: RV32I/RV64I immediate decoder feeding a 2-entry skid buffer.
// Decode is combinational on the input; results leave one cycle after accept.
module imm_gen_pipe #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [XLEN-1:0] out_target,
    output logic [2:0]      out_fmt,
    output logic            out_illegal
);
    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] target;
        logic [2:0]      fmt;
        logic            illegal;
    } res_t;

    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;

    localparam logic [2:0] F_NONE  = 3'd0;
    localparam logic [2:0] F_I     = 3'd1;
    localparam logic [2:0] F_S     = 3'd2;
    localparam logic [2:0] F_B     = 3'd3;
    localparam logic [2:0] F_U     = 3'd4;
    localparam logic [2:0] F_J     = 3'd5;
    localparam logic [2:0] F_SHAMT = 3'd6;
    localparam logic [2:0] F_CSR   = 3'd7;

    logic [2:0]      f3;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] imm_j;
    logic [XLEN-1:0] imm_csr;
    logic [XLEN-1:0] shamt;
    logic            sh_zero;
    logic            sh_alt;
    logic            pc_rel;
    res_t            dec;
    res_t            m_q;
    res_t            s_q;
    logic            m_valid;
    logic            s_valid;
    logic            accept;
    logic            m_load;

    assign f3      = in_instr[14:12];
    assign imm_i   = XLEN'($signed(in_instr[31:20]));
    assign imm_s   = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
    assign imm_b   = XLEN'($signed({in_instr[31], in_instr[7],
                                    in_instr[30:25], in_instr[11:8], 1'b0}));
    assign imm_u   = XLEN'($signed({in_instr[31:12], 12'b0}));
    assign imm_j   = XLEN'($signed({in_instr[31], in_instr[19:12],
                                    in_instr[20], in_instr[30:21], 1'b0}));
    assign imm_csr = XLEN'(in_instr[19:15]);

    // RV64 shifts borrow instr[25] for shamt[5], shrinking the funct field
    if (XLEN == 64) begin : g_sh64
        assign shamt   = XLEN'(in_instr[25:20]);
        assign sh_zero = in_instr[31:26] == 6'b000000;
        assign sh_alt  = in_instr[31:26] == 6'b010000;
    end else begin : g_sh32
        assign shamt   = XLEN'(in_instr[24:20]);
        assign sh_zero = in_instr[31:25] == 7'b0000000;
        assign sh_alt  = in_instr[31:25] == 7'b0100000;
    end

    always_comb begin
        dec    = '0;
        pc_rel = 1'b0;
        unique case (in_instr[6:0])
            OPC_OPIMM: begin
                if (f3[1:0] == 2'b01) begin
                    dec.fmt     = F_SHAMT;
                    dec.imm     = shamt;
                    dec.illegal = !(sh_zero || sh_alt) || (sh_alt && !f3[2]);
                end else begin
                    dec.fmt = F_I;
                    dec.imm = imm_i;
                end
            end
            OPC_LOAD, OPC_JALR: begin
                dec.fmt = F_I;
                dec.imm = imm_i;
            end
            OPC_STORE: begin
                dec.fmt = F_S;
                dec.imm = imm_s;
            end
            OPC_BRANCH: begin
                dec.fmt = F_B;
                dec.imm = imm_b;
                pc_rel  = 1'b1;
            end
            OPC_JAL: begin
                dec.fmt = F_J;
                dec.imm = imm_j;
                pc_rel  = 1'b1;
            end
            OPC_LUI: begin
                dec.fmt = F_U;
                dec.imm = imm_u;
            end
            OPC_AUIPC: begin
                dec.fmt = F_U;
                dec.imm = imm_u;
                pc_rel  = 1'b1;
            end
            OPC_SYSTEM: begin
                if (f3[2]) begin
                    dec.fmt = F_CSR;
                    dec.imm = imm_csr;
                end
            end
            OPC_OP, OPC_FENCE: begin
                dec.fmt = F_NONE;
            end
            default: dec.illegal = 1'b1;
        endcase
        if (pc_rel) dec.target = in_pc + dec.imm;
    end

    // in_ready depends only on registered state, never on out_ready
    assign in_ready = !s_valid && !rst;
    assign accept   = in_valid && in_ready;
    assign m_load   = !m_valid || out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid <= 1'b0;
            s_valid <= 1'b0;
            m_q     <= '0;
            s_q     <= '0;
        end else if (m_load) begin
            if (s_valid) begin
                m_q     <= s_q;
                m_valid <= 1'b1;
                s_valid <= 1'b0;
            end else begin
                m_valid <= accept;
                if (accept) m_q <= dec;
            end
        end else if (accept) begin
            s_q     <= dec;
            s_valid <= 1'b1;
        end
    end

    assign out_valid   = m_valid;
    assign out_imm     = m_q.imm;
    assign out_target  = m_q.target;
    assign out_fmt     = m_q.fmt;
    assign out_illegal = m_q.illegal;
endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Pipelined, parametrised immediate generator for the decode stage. It accepts one 32-bit RV32I/RV64I instruction word plus its PC per valid/ready transfer. It produces the sign-extended XLEN-wide immediate, a format code, the PC-relative target and an illegal-encoding flag, one cycle later through a 2-entry skid buffer. It sits between fetch and the register-read/ALU stages and supersedes the single-cycle combinational immediate decoder.

## Interface
- XLEN, 32, datapath width; legal values 32 or 64
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  instruction/PC present
- in_ready  out  1  block can accept this cycle
- in_instr  in  32  instruction word
- in_pc  in  XLEN  address of in_instr
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts this cycle
- out_imm  out  XLEN  decoded immediate
- out_target  out  XLEN  pc+imm for BRANCH/JAL/AUIPC, else 0
- out_fmt  out  3  0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT, 7 CSR
- out_illegal  out  1  unsupported opcode or malformed shift

## Operation
- Decode on instr[6:0], f3 = instr[14:12]; all immediates sign-extended from instr[31] to XLEN unless noted.
- OP-IMM 0010011: f3 001/101 → SHAMT, imm = zero-extended instr[24:20] (XLEN=32) or instr[25:20] (XLEN=64). Illegal if the upper funct bits (instr[31:25] for XLEN=32, instr[31:26] for XLEN=64) are neither all-zero nor 0100000/010000. A nonzero "0100000" form with f3=001 is also illegal. Other f3 → I.
- LOAD 0000011, JALR 1100111 → I. STORE 0100011 → S. BRANCH 1100011 → B (bit0 = 0). JAL 1101111 → J (bit0 = 0).
- LUI 0110111, AUIPC 0010111 → U: {instr[31:12], 12'b0}, sign-extended to XLEN.
- SYSTEM 1110011: f3[2]=1 → CSR, imm = zero-extended instr[19:15]; otherwise NONE.
- OP 0110011, FENCE 0001111 → NONE, imm 0, legal.
- Any other opcode → NONE, imm 0, target 0, out_illegal=1.
- out_target = in_pc + imm modulo 2^XLEN (wraps, no flag) for BRANCH, JAL, AUIPC; 0 otherwise.
- Decode is combinational on the input side; the result is captured into the skid structure.

## Timing
- Skid buffer: main register M (drives outputs) and skid register S, each with a valid bit.
- Accept when in_valid && in_ready. Output transfer when out_valid && out_ready.
- in_ready = !S.valid && !rst (registered state only; no combinational path from out_ready).
- out_valid = M.valid.
- Per cycle, not in reset:
  - M empty, or M transferring: M ← S if S valid, else ← accepted input.
  - If S was valid, accepted input (impossible, in_ready=0) is excluded; S ← empty when drained to M.
  - M full and not transferring, input accepted: S ← input.
- Latency: input accepted at edge N appears on outputs after edge N; out_valid is high in cycle N+1.
- Throughput: 1 per cycle with out_ready held high.
- Order strictly preserved; no drops, no duplicates.
- Payload registers hold value while out_valid && !out_ready.
- Reset (sync, any cycle, including mid-stall): M.valid=S.valid=0; out_imm, out_target, out_fmt, out_illegal = 0. in_ready=0 while rst is high, 1 in the first cycle after. In-flight entries are discarded.

## Test plan
- XLEN=32, out_ready=1, in_instr 0xFFF00093 (addi x1,x0,-1) → next cycle out_fmt=1, out_imm 0xFFFFFFFF, out_illegal=0.
- in_instr 0xFE000EE3 (beq -4), in_pc 0x100 → out_fmt=3, out_imm 0xFFFFFFFC, out_target 0x000000FC. Also 0x12345297 (auipc), pc 0x1000 → imm 0x12345000, target 0x12346000.
- Shifts: 0x4030D093 (srai 3) → fmt 6, imm 3, legal. 0x02209093 (slli, instr[25]=1, XLEN=32) → out_illegal=1. Opcode 0x7F → fmt 0, imm 0, illegal.
- Backpressure: out_ready=0, push A, B → in_ready low after B, C held off. Raise out_ready → A, B, C delivered in order on consecutive cycles, C accepted the cycle after in_ready returns.
- Reset with M and S full → outputs all 0 and out_valid=0 next cycle, in_ready=0 during rst, 1 after. No stale entry is delivered.
- XLEN=64: 0x800000B7 (lui 0x80000) → imm 0xFFFFFFFF80000000. slli with shamt 33 (0x02109093) → fmt 6, imm 33, legal.
